// File: rtl/gfx_cmd_processor.sv
// Graphics command processor: fetches a command list from DRAM in refills of
// FETCH_REQS requests and issues FILL commands to the frame filler and LINE commands to the line engine.
module gfx_cmd_processor #(
    parameter int FETCH_REQS = 2,
    parameter int COLOR_W    = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  GP_CODE,
    input  logic [31:0]  GP_FRAME,
    input  logic         GP_valid,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         LE_ready,
    output logic [31:0]  LE_color,
    output logic [9:0]   LE_point,
    output logic         LE_color_valid,
    output logic         LE_x0_valid,
    output logic         LE_y0_valid,
    output logic         LE_x1_valid,
    output logic         LE_y1_valid,
    output logic         LE_trigger,
    output logic [31:0]  LE_frame,
    input  logic         FF_ready,
    output logic         FF_valid,
    output logic [23:0]  FF_color,
    output logic [31:0]  FF_frame,
    input  logic         af_full,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    input  logic         rdf_valid,
    input  logic [127:0] rdf_dout,
    output logic         rdf_rd_en,
    output logic [2:0]   dbg_state
);
    localparam int NW    = 8 * FETCH_REQS;
    localparam int NB    = 2 * FETCH_REQS;
    localparam int IDX_W = $clog2(NW);
    localparam int PC_W  = IDX_W + 1;
    localparam int BC_W  = $clog2(NB) + 1;
    localparam int RC_W  = $clog2(FETCH_REQS) + 1;

    typedef enum logic [2:0] {IDLE, REQ, READ, DECODE, FILL, LINE} state_t;

    state_t          state;
    logic [31:0]     frame_q;
    logic [30:0]     fetch_addr;
    logic [RC_W-1:0] rcnt;
    logic [BC_W-1:0] bcnt;
    logic [PC_W-1:0] pc;
    logic [2:0]      elem;
    logic            line_pending;
    logic [31:0]     cmd_buf [NW];
    logic [31:0]     cur_word;
    logic            buf_empty;
    logic            unused_bits;

    // Only the 21-bit word-pair index of the command address is ever fetched.
    assign unused_bits = ^{GP_CODE[31:24], GP_CODE[2:0]};

    // Strict valid/ready: a DRAM address moves when af_wr_en is high (af_full low),
    // a read beat moves when rdf_rd_en is high (rdf_valid high); both only outside reset.
    assign af_wr_en    = (state == REQ) && !af_full && !rst;
    assign rdf_rd_en   = (state == READ) && rdf_valid && !rst;
    assign af_addr_din = fetch_addr;
    assign busy        = (state != IDLE) && !rst;
    assign LE_frame    = frame_q;
    assign FF_frame    = frame_q;
    assign dbg_state   = state;

    assign buf_empty = (pc == PC_W'(NW));

    always_comb begin
        cur_word = '0;
        if (!buf_empty) cur_word = cmd_buf[pc[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rdf_rd_en) begin
            for (int k = 0; k < 4; k++) begin
                cmd_buf[{bcnt[IDX_W-3:0], 2'(k)}] <= rdf_dout[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rcnt           <= '0;
            bcnt           <= '0;
            pc             <= '0;
            elem           <= '0;
            line_pending   <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            FF_valid       <= 1'b0;
            LE_color_valid <= 1'b0;
            LE_x0_valid    <= 1'b0;
            LE_y0_valid    <= 1'b0;
            LE_x1_valid    <= 1'b0;
            LE_y1_valid    <= 1'b0;
            LE_trigger     <= 1'b0;
        end else begin
            done           <= 1'b0;
            FF_valid       <= 1'b0;
            LE_color_valid <= 1'b0;
            LE_x0_valid    <= 1'b0;
            LE_y0_valid    <= 1'b0;
            LE_x1_valid    <= 1'b0;
            LE_y1_valid    <= 1'b0;
            LE_trigger     <= 1'b0;
            case (state)
                IDLE: begin
                    if (GP_valid) begin
                        frame_q      <= GP_FRAME;
                        fetch_addr   <= {10'b0, GP_CODE[23:3]};
                        err          <= 1'b0;
                        rcnt         <= '0;
                        bcnt         <= '0;
                        pc           <= '0;
                        elem         <= '0;
                        line_pending <= 1'b0;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (!af_full) begin
                        fetch_addr <= fetch_addr + 31'd4;
                        rcnt       <= rcnt + RC_W'(1);
                        if (rcnt == RC_W'(FETCH_REQS - 1)) begin
                            rcnt  <= '0;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (rdf_valid) begin
                        bcnt <= bcnt + BC_W'(1);
                        if (bcnt == BC_W'(NB - 1)) begin
                            bcnt  <= '0;
                            pc    <= '0;
                            state <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    if (buf_empty) begin
                        state <= REQ;
                    end else if (line_pending) begin
                        state <= LINE;
                    end else begin
                        case (cur_word[31:24])
                            8'h00: begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                            8'h01: begin
                                if (FF_ready && LE_ready) begin
                                    FF_valid <= 1'b1;
                                    FF_color <= 24'(cur_word[COLOR_W-1:0]);
                                    pc       <= pc + PC_W'(1);
                                    state    <= FILL;
                                end
                            end
                            8'h02: begin
                                if (FF_ready && LE_ready) begin
                                    LE_color_valid <= 1'b1;
                                    LE_color       <= 32'(cur_word[COLOR_W-1:0]);
                                    pc             <= pc + PC_W'(1);
                                    elem           <= 3'd1;
                                    line_pending   <= 1'b1;
                                    state          <= LINE;
                                end
                            end
                            default: begin
                                err <= 1'b1;
                                pc  <= pc + PC_W'(1);
                            end
                        endcase
                    end
                end
                FILL: state <= DECODE;
                LINE: begin
                    // A point word past the buffer end parks the line until the next refill.
                    if (buf_empty) begin
                        state <= REQ;
                    end else begin
                        case (elem)
                            3'd1: begin
                                LE_x0_valid <= 1'b1;
                                LE_point    <= cur_word[25:16];
                                elem        <= 3'd2;
                            end
                            3'd2: begin
                                LE_y0_valid <= 1'b1;
                                LE_point    <= cur_word[9:0];
                                pc          <= pc + PC_W'(1);
                                elem        <= 3'd3;
                            end
                            3'd3: begin
                                LE_x1_valid <= 1'b1;
                                LE_point    <= cur_word[25:16];
                                elem        <= 3'd4;
                            end
                            3'd4: begin
                                LE_y1_valid  <= 1'b1;
                                LE_trigger   <= 1'b1;
                                LE_point     <= cur_word[9:0];
                                pc           <= pc + PC_W'(1);
                                elem         <= 3'd0;
                                line_pending <= 1'b0;
                                state        <= DECODE;
                            end
                            default: begin
                                elem         <= 3'd0;
                                line_pending <= 1'b0;
                                state        <= DECODE;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
